alu_seq: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Adds a start/busy/done handshake, a compact opcode, an iterative signed multiplier and an iterative signed divider.
- Produces a double-width HI:LO result.
- Sits between the register file / operand latches (A, B) and the HI/LO/Z result registers of the CPU datapath.

---
 rtl/alu_seq_if.sv | 24 ++
 rtl/alu_seq.sv | 145 ++++++++++++++
 tb/tb_alu_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Operand/opcode request and HI:LO result bundle between the datapath and alu_seq.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic [3:0]             op;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic [2*WIDTH-1:0]     C;
    logic                   busy;
    logic                   done;
    logic                   div0;
    logic                   err;

    modport master (
        output start, op, A, B,
        input  C, busy, done, div0, err
    );

    modport slave (
        input  start, op, A, B,
        output C, busy, done, div0, err
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: logic/shift ops done 1 cycle after accept, MUL/DIV done WIDTH+1 edges after accept.
// No queueing: start is only sampled while busy=0, requests during busy are dropped.
module alu_seq #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      clr,
    alu_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    localparam logic [3:0] OP_AND = 4'd0,  OP_OR  = 4'd1,  OP_ADD = 4'd2,  OP_SUB = 4'd3;
    localparam logic [3:0] OP_MUL = 4'd4,  OP_DIV = 4'd5,  OP_SHR = 4'd6,  OP_SHL = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8,  OP_ROL = 4'd9,  OP_NEG = 4'd10, OP_NOT = 4'd11;

    state_t               state, state_nxt;
    logic                 accept, op_mul, op_div, op_multi, b_zero;
    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [SHW-1:0]       sh, sh_n;
    logic [WIDTH-1:0]     alu_lo;
    logic                 illegal;

    logic [SHW-1:0]       cnt;
    logic [2*WIDTH-1:0]   acc, acc_nxt, fix_c;
    logic [WIDTH-1:0]     opnd, a_q, acc_hi, acc_lo, quo, rem;
    logic [WIDTH:0]       mul_sum, div_trial;
    logic                 is_div, sgn, rsgn, dz;

    logic [2*WIDTH-1:0]   c_q;
    logic                 done_q, div0_q, err_q;

    assign bus.C    = c_q;
    assign bus.done = done_q;
    assign bus.div0 = div0_q;
    assign bus.err  = err_q;
    assign bus.busy = (state != IDLE);

    assign accept   = bus.start && (state == IDLE);
    assign op_mul   = (bus.op == OP_MUL);
    assign op_div   = (bus.op == OP_DIV);
    assign op_multi = op_mul || op_div;
    assign b_zero   = (bus.B == '0);
    assign a_abs    = bus.A[WIDTH-1] ? -bus.A : bus.A;
    assign b_abs    = bus.B[WIDTH-1] ? -bus.B : bus.B;

    // Rotates use the complementary amount modulo WIDTH, so an amount of 0 yields A|A = A.
    assign sh   = bus.B[SHW-1:0];
    assign sh_n = ~sh + 1'b1;

    always_comb begin
        alu_lo  = '0;
        illegal = 1'b0;
        case (bus.op)
            OP_AND:         alu_lo = bus.A & bus.B;
            OP_OR:          alu_lo = bus.A | bus.B;
            OP_ADD:         alu_lo = bus.A + bus.B;
            OP_SUB:         alu_lo = bus.A - bus.B;
            OP_SHR:         alu_lo = bus.A >> sh;
            OP_SHL:         alu_lo = bus.A << sh;
            OP_ROR:         alu_lo = (bus.A >> sh) | (bus.A << sh_n);
            OP_ROL:         alu_lo = (bus.A << sh) | (bus.A >> sh_n);
            OP_NEG:         alu_lo = -bus.A;
            OP_NOT:         alu_lo = ~bus.A;
            OP_MUL, OP_DIV: alu_lo = '0;
            default:        illegal = 1'b1;
        endcase
    end

    // acc holds HI:LO; MUL shifts the product in from the top, DIV shifts quotient bits into LO.
    always_comb begin
        acc_hi    = acc[2*WIDTH-1:WIDTH];
        acc_lo    = acc[WIDTH-1:0];
        mul_sum   = {1'b0, acc_hi} + {1'b0, (acc[0] ? opnd : '0)};
        div_trial = {acc_hi, acc[WIDTH-1]} - {1'b0, opnd};
        if (is_div) begin
            acc_nxt = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                       : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        end
        quo = sgn  ? -acc_lo : acc_lo;
        rem = rsgn ? -acc_hi : acc_hi;
        if (dz)          fix_c = {a_q, {WIDTH{1'b1}}};
        else if (is_div) fix_c = {rem, quo};
        else             fix_c = sgn ? -acc : acc;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && op_multi) state_nxt = (op_div && b_zero) ? FIX : ITER;
            ITER: if (&cnt) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            a_q    <= '0;
            is_div <= 1'b0;
            sgn    <= 1'b0;
            rsgn   <= 1'b0;
            dz     <= 1'b0;
            c_q    <= '0;
            done_q <= 1'b0;
            div0_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_q    <= bus.A;
                is_div <= op_div;
                sgn    <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                rsgn   <= bus.A[WIDTH-1];
                dz     <= op_div && b_zero;
                cnt    <= '0;
                opnd   <= op_div ? b_abs : a_abs;
                acc    <= {{WIDTH{1'b0}}, (op_div ? a_abs : b_abs)};
                err_q  <= illegal;
                div0_q <= 1'b0;
                if (!op_multi) begin
                    c_q    <= {{WIDTH{1'b0}}, alu_lo};
                    done_q <= 1'b1;
                end
            end else if (state == ITER) begin
                cnt <= cnt + 1'b1;
                acc <= acc_nxt;
            end else if (state == FIX) begin
                c_q    <= fix_c;
                done_q <= 1'b1;
                div0_q <= dz;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_alu_seq;
    localparam logic [3:0] OP_AND = 4'd0, OP_ADD = 4'd2, OP_SUB = 4'd3, OP_MUL = 4'd4;
    localparam logic [3:0] OP_DIV = 4'd5, OP_SHR = 4'd6, OP_ROR = 4'd8;

    typedef struct packed {
        logic [63:0] c;
        logic        div0;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(32)) b32 ();
    alu_seq_if #(.WIDTH(8))  b8 ();

    alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .clr(clr), .bus(b32));
    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .clr(clr), .bus(b8));

    exp_t        q32[$];
    exp_t        q8[$];
    exp_t        ex32, ex8;
    int          tests = 0;
    int          fails = 0;
    int          lat, bc;
    logic [3:0]  rop;
    logic [31:0] ra, rb;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] c, input logic d0, input logic er);
        return {c, d0, er};
    endfunction

    // Signed interpretation of the operands, then the arithmetic straight from the opcode table.
    function automatic exp_t model(input int w, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned mask, ua, ub, lo, hi, c;
        longint          sa, sb, p;
        int              sh;
        logic            d0, er;
        mask = (64'd1 << w) - 64'd1;
        ua = {32'd0, a} & mask;
        ub = {32'd0, b} & mask;
        sa = ua;
        if (ua >= (64'd1 << (w - 1))) sa = sa - (longint'(1) << w);
        sb = ub;
        if (ub >= (64'd1 << (w - 1))) sb = sb - (longint'(1) << w);
        sh = int'(ub & 64'(w - 1));
        lo = 0; hi = 0; c = 0; d0 = 1'b0; er = 1'b0;
        case (op)
            4'd0:  lo = ua & ub;
            4'd1:  lo = ua | ub;
            4'd2:  lo = ua + ub;
            4'd3:  lo = ua - ub;
            4'd4:  lo = 0;
            4'd5:  if (ub == 0) begin lo = mask; hi = ua; d0 = 1'b1; end
                   else begin lo = sa / sb; hi = sa % sb; end
            4'd6:  lo = ua >> sh;
            4'd7:  lo = ua << sh;
            4'd8:  lo = (ua >> sh) | (ua << (w - sh));
            4'd9:  lo = (ua << sh) | (ua >> (w - sh));
            4'd10: lo = 64'd0 - ua;
            4'd11: lo = ~ua;
            default: er = 1'b1;
        endcase
        if (op == 4'd4) begin
            p = sa * sb;
            c = p;
            if (w < 32) c = c & ((64'd1 << (2 * w)) - 64'd1);
        end else begin
            c = ((hi & mask) << w) | (lo & mask);
        end
        return {c, d0, er};
    endfunction

    function automatic logic [31:0] pick(input int w);
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1 << (w - 1);
            4:       return (32'd1 << (w - 1)) - 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Called on a falling edge; returns on the falling edge after the accept edge.
    // mode: 0 no expectation, 1 reference model, 2 explicit expectation e.
    task automatic issue(input bit w8, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int mode, input exp_t e);
        if (w8) begin
            b8.start = 1'b1; b8.op = op; b8.A = a[7:0]; b8.B = b[7:0];
            if (mode == 1) q8.push_back(model(8, op, a, b));
            else if (mode == 2) q8.push_back(e);
        end else begin
            b32.start = 1'b1; b32.op = op; b32.A = a; b32.B = b;
            if (mode == 1) q32.push_back(model(32, op, a, b));
            else if (mode == 2) q32.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        b32.start = 1'b0; b8.start = 1'b0;
        b32.A = $urandom; b32.B = $urandom; b32.op = 4'($urandom);
        b8.A = 8'($urandom); b8.B = 8'($urandom); b8.op = 4'($urandom);
    endtask

    task automatic wait_done(input bit w8, output int l, output int bcnt);
        l = 0; bcnt = 0;
        while (!(w8 ? b8.done : b32.done) && l < 200) begin
            if (w8 ? b8.busy : b32.busy) bcnt++;
            @(negedge clk);
            l++;
        end
        chk("done_seen", 66'(w8 ? b8.done : b32.done), 66'(1));
        @(negedge clk);
        chk("done_one_pulse", 66'(w8 ? b8.done : b32.done), 66'(0));
    endtask

    initial begin
        b32.start = 1'b0; b32.op = '0; b32.A = '0; b32.B = '0;
        b8.start = 1'b0;  b8.op = '0;  b8.A = '0;  b8.B = '0;

        fork
            forever begin
                @(negedge clk);
                if (b32.done === 1'b1) begin
                    chk("w32_done_has_pending", 66'(q32.size() != 0), 66'(1));
                    if (q32.size() != 0) begin
                        ex32 = q32.pop_front();
                        chk("w32_result", {b32.C, b32.div0, b32.err}, ex32);
                    end
                end
                if (b8.done === 1'b1) begin
                    chk("w8_done_has_pending", 66'(q8.size() != 0), 66'(1));
                    if (q8.size() != 0) begin
                        ex8 = q8.pop_front();
                        chk("w8_result", {48'd0, b8.C, b8.div0, b8.err}, ex8);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("reset_C", 66'(b32.C), 66'(0));
        chk("reset_flags", 66'({b32.busy, b32.done, b32.div0, b32.err}), 66'(0));
        chk("reset_C_w8", 66'(b8.C), 66'(0));
        clr = 1'b1;
        @(negedge clk);

        issue(0, OP_ADD, 32'd3, 32'd4, 2, mk(64'h0000_0000_0000_0007, 1'b0, 1'b0));
        chk("add_busy_low", 66'(b32.busy), 66'(0));
        chk("add_done_next_cycle", 66'(b32.done), 66'(1));
        issue(0, OP_SUB, 32'd3, 32'd4, 2, mk(64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0));
        chk("sub_back_to_back_done", 66'(b32.done), 66'(1));
        @(negedge clk);

        issue(0, OP_MUL, -32'sd3, 32'd4, 2, mk(64'hFFFF_FFFF_FFFF_FFF4, 1'b0, 1'b0));
        wait_done(0, lat, bc);
        chk("mul_latency", 66'(lat), 66'(33));
        chk("mul_busy_cycles", 66'(bc), 66'(33));
        issue(0, OP_MUL, 32'h8000_0000, 32'h8000_0000, 2, mk(64'h4000_0000_0000_0000, 1'b0, 1'b0));
        wait_done(0, lat, bc);

        issue(0, OP_DIV, -32'sd7, 32'd2, 2, mk(64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0));
        wait_done(0, lat, bc);
        chk("div_latency", 66'(lat), 66'(33));
        issue(0, OP_DIV, 32'd9, 32'd0, 2, mk(64'h0000_0009_FFFF_FFFF, 1'b1, 1'b0));
        wait_done(0, lat, bc);
        chk("div0_latency", 66'(lat), 66'(1));
        chk("div0_sticky", 66'(b32.div0), 66'(1));
        issue(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 2, mk(64'h0000_0000_8000_0000, 1'b0, 1'b0));
        wait_done(0, lat, bc);

        issue(0, OP_ROR, 32'h0000_0001, 32'h0000_0021, 2, mk(64'h0000_0000_8000_0000, 1'b0, 1'b0));
        issue(0, OP_SHR, 32'h8000_0000, 32'd31, 2, mk(64'h0000_0000_0000_0001, 1'b0, 1'b0));
        issue(0, 4'd13, 32'h1234_5678, 32'h9ABC_DEF0, 2, mk(64'd0, 1'b0, 1'b1));
        @(negedge clk);
        chk("err_sticky", 66'(b32.err), 66'(1));
        issue(0, OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 2, mk(64'h0000_0000_F000_F000, 1'b0, 1'b0));
        @(negedge clk);

        issue(0, OP_MUL, 32'd12345, 32'hFFFF_FF00, 1, '0);
        repeat (4) @(negedge clk);
        b32.start = 1'b1; b32.op = OP_DIV; b32.A = 32'd100; b32.B = 32'd7;
        @(negedge clk);
        b32.start = 1'b0;
        wait_done(0, lat, bc);
        chk("mul_ignores_start_latency", 66'(lat), 66'(28));

        issue(0, OP_MUL, 32'd7, 32'd9, 0, '0);
        repeat (9) @(negedge clk);
        clr = 1'b0;
        #1;
        chk("abort_C", 66'(b32.C), 66'(0));
        chk("abort_busy", 66'(b32.busy), 66'(0));
        @(negedge clk);
        clr = 1'b1;
        repeat (40) @(negedge clk);
        issue(0, OP_MUL, -32'sd1000, 32'd77, 1, '0);
        wait_done(0, lat, bc);
        chk("mul_after_abort_latency", 66'(lat), 66'(33));

        for (int i = 0; i < 150; i++) begin
            rop = ($urandom_range(0, 3) == 0) ? 4'(4 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15));
            ra = pick(32);
            rb = pick(32);
            issue(0, rop, ra, rb, 1, '0);
            if (rop == OP_MUL || rop == OP_DIV) begin
                wait_done(0, lat, bc);
                chk("w32_rand_latency", 66'(lat), 66'((rop == OP_DIV && rb == 32'd0) ? 1 : 33));
            end
        end
        @(negedge clk);

        issue(1, OP_MUL, 32'h80, 32'hFF, 2, mk(64'h0080, 1'b0, 1'b0));
        wait_done(1, lat, bc);
        chk("w8_mul_latency", 66'(lat), 66'(9));
        chk("w8_mul_busy_cycles", 66'(bc), 66'(9));
        issue(1, OP_DIV, 32'd100, 32'hF9, 2, mk(64'h02F2, 1'b0, 1'b0));
        wait_done(1, lat, bc);
        for (int i = 0; i < 80; i++) begin
            rop = ($urandom_range(0, 3) == 0) ? 4'(4 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15));
            ra = pick(8);
            rb = pick(8);
            issue(1, rop, ra, rb, 1, '0);
            if (rop == OP_MUL || rop == OP_DIV) begin
                wait_done(1, lat, bc);
                chk("w8_rand_latency", 66'(lat), 66'((rop == OP_DIV && rb[7:0] == 8'd0) ? 1 : 9));
            end
        end

        repeat (45) @(negedge clk);
        chk("w32_queue_drained", 66'(q32.size()), 66'(0));
        chk("w8_queue_drained", 66'(q8.size()), 66'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
